// File: rtl/mc_controller.sv
// Main control unit of the multicycle MIPS core: a Moore FSM with registered
// control outputs, an ALU decoder and a sticky illegal-opcode flag.
module mc_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       irwrite,
   output logic       regwrite,
   output logic       memwrite,
   output logic       alusrca,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEXEC = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   typedef struct packed {
      logic       pcwrite;
      logic       branch;
      logic       irwrite;
      logic       regwrite;
      logic       memwrite;
      logic       alusrca;
      logic       iord;
      logic       memtoreg;
      logic       regdst;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
   } ctrl_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   function automatic ctrl_t decode_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.irwrite = 1'b1;
            c.pcwrite = 1'b1;
            c.alusrcb = 2'b01;
         end
         S_DECODE:   c.alusrcb = 2'b11;
         S_MEMADR: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
         end
         S_MEMRD:    c.iord = 1'b1;
         S_MEMWB: begin
            c.memtoreg = 1'b1;
            c.regwrite = 1'b1;
         end
         S_MEMWR: begin
            c.iord     = 1'b1;
            c.memwrite = 1'b1;
         end
         S_EXECUTE:  c.alusrca = 1'b1;
         S_ALUWB: begin
            c.regdst   = 1'b1;
            c.regwrite = 1'b1;
         end
         S_BRANCH: begin
            c.alusrca = 1'b1;
            c.pcsrc   = 2'b01;
            c.branch  = 1'b1;
         end
         S_ADDIEXEC: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
         end
         S_ADDIWB:   c.regwrite = 1'b1;
         S_JUMP: begin
            c.pcsrc   = 2'b10;
            c.pcwrite = 1'b1;
         end
         default:    c = '0;
      endcase
      return c;
   endfunction

   function automatic logic [1:0] state_aluop(input state_t s);
      logic [1:0] a;
      case (s)
         S_EXECUTE: a = 2'b10;
         S_BRANCH:  a = 2'b01;
         default:   a = 2'b00;
      endcase
      return a;
   endfunction

   function automatic logic [2:0] alu_decode(input logic [1:0] aluop, input logic [5:0] fn);
      logic [2:0] r;
      case (aluop)
         2'b01: r = 3'b110;
         2'b10: begin
            case (fn)
               6'b100000: r = 3'b010;
               6'b100010: r = 3'b110;
               6'b100100: r = 3'b000;
               6'b100101: r = 3'b001;
               6'b101010: r = 3'b111;
               default:   r = 3'b010;
            endcase
         end
         default: r = 3'b010;
      endcase
      return r;
   endfunction

   state_t     state_r;
   state_t     next_s;
   ctrl_t      ctrl_r;
   ctrl_t      ctrl_next_s;
   logic [2:0] alucontrol_r;
   logic [2:0] alu_next_s;
   logic       illegal_r;
   logic       illegal_set_s;

   // Next-state selection; opcode only steers the path in DECODE and MEMADR.
   always_comb begin
      next_s        = S_FETCH;
      illegal_set_s = 1'b0;
      case (state_r)
         S_FETCH:  next_s = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: next_s = S_MEMADR;
               OP_RTYPE:     next_s = S_EXECUTE;
               OP_BEQ:       next_s = S_BRANCH;
               OP_ADDI:      next_s = S_ADDIEXEC;
               OP_J:         next_s = S_JUMP;
               default: begin
                  next_s        = S_FETCH;
                  illegal_set_s = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LW) begin
               next_s = S_MEMRD;
            end else begin
               next_s = S_MEMWR;
            end
         end
         S_MEMRD:    next_s = S_MEMWB;
         S_EXECUTE:  next_s = S_ALUWB;
         S_ADDIEXEC: next_s = S_ADDIWB;
         default:    next_s = S_FETCH;
      endcase
      ctrl_next_s = decode_ctrl(next_s);
      alu_next_s  = alu_decode(state_aluop(next_s), funct);
   end

   // State plus controls for the state being entered, so outputs come straight from flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= S_FETCH;
         ctrl_r       <= decode_ctrl(S_FETCH);
         alucontrol_r <= 3'b010;
         illegal_r    <= 1'b0;
      end else begin
         state_r      <= next_s;
         ctrl_r       <= ctrl_next_s;
         alucontrol_r <= alu_next_s;
         illegal_r    <= illegal_r | illegal_set_s;
      end
   end

   // pcen is the one output that must follow zero within the BRANCH cycle.
   assign pcen       = ctrl_r.pcwrite | (ctrl_r.branch & zero);
   assign irwrite    = ctrl_r.irwrite;
   assign regwrite   = ctrl_r.regwrite;
   assign memwrite   = ctrl_r.memwrite;
   assign alusrca    = ctrl_r.alusrca;
   assign iord       = ctrl_r.iord;
   assign memtoreg   = ctrl_r.memtoreg;
   assign regdst     = ctrl_r.regdst;
   assign alusrcb    = ctrl_r.alusrcb;
   assign pcsrc      = ctrl_r.pcsrc;
   assign alucontrol = alucontrol_r;
   assign illegal    = illegal_r;
   assign state      = state_r;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: an instruction-level path model checked every cycle,
// plus directed instruction runs with hand-computed traces and masks.
module tb_mc_controller;
   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;
   logic       pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic       illegal;
   logic [3:0] state;

   mc_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
      .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
      .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction-level model: each opcode fixes the list of states it walks through.
   int         m_state = 0;
   bit         m_illegal = 1'b0;
   int         m_path[$];
   logic [5:0] m_op = 6'd0;

   function automatic bit known_op(input logic [5:0] o);
      return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
             (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_state   = 0;
         m_illegal = 1'b0;
         m_path.delete();
      end else if (m_state == 0) begin
         m_op = op;
         case (op)
            6'b100011: m_path = '{1, 2, 3, 4};
            6'b101011: m_path = '{1, 2, 5};
            6'b000000: m_path = '{1, 6, 7};
            6'b000100: m_path = '{1, 8};
            6'b001000: m_path = '{1, 9, 10};
            6'b000010: m_path = '{1, 11};
            default:   m_path = '{1};
         endcase
         m_state = m_path.pop_front();
      end else begin
         if (m_state == 1 && !known_op(m_op)) m_illegal = 1'b1;
         if (m_path.size() > 0) m_state = m_path.pop_front();
         else m_state = 0;
      end
   end

   // Control table per state: pcwrite branch irwrite regwrite memwrite alusrca
   // iord memtoreg regdst alusrcb[2] pcsrc[2] aluop[2]
   function automatic logic [14:0] spec_row(input int s);
      case (s)
         0:  return 15'b1_0_1_0_0_0_0_0_0_01_00_00;
         1:  return 15'b0_0_0_0_0_0_0_0_0_11_00_00;
         2:  return 15'b0_0_0_0_0_1_0_0_0_10_00_00;
         3:  return 15'b0_0_0_0_0_0_1_0_0_00_00_00;
         4:  return 15'b0_0_0_1_0_0_0_1_0_00_00_00;
         5:  return 15'b0_0_0_0_1_0_1_0_0_00_00_00;
         6:  return 15'b0_0_0_0_0_1_0_0_0_00_00_10;
         7:  return 15'b0_0_0_1_0_0_0_0_1_00_00_00;
         8:  return 15'b0_1_0_0_0_1_0_0_0_00_01_01;
         9:  return 15'b0_0_0_0_0_1_0_0_0_10_00_00;
         10: return 15'b0_0_0_1_0_0_0_0_0_00_00_00;
         11: return 15'b1_0_0_0_0_0_0_0_0_00_10_00;
         default: return 15'b0;
      endcase
   endfunction

   function automatic logic [2:0] exp_alu(input logic [1:0] aluop, input logic [5:0] fn);
      if (aluop == 2'b01) return 3'b110;
      if (aluop != 2'b10) return 3'b010;
      case (fn)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [14:0] r;
         logic [19:0] exp_v, act_v;
         r = spec_row(m_state);
         exp_v = {m_state[3:0], m_illegal, r[14] | (r[13] & zero), r[12], r[11], r[10],
                  r[9], r[8], r[7], r[6], r[5:4], r[3:2], exp_alu(r[1:0], funct)};
         act_v = {state, illegal, pcen, irwrite, regwrite, memwrite, alusrca, iord,
                  memtoreg, regdst, alusrcb, pcsrc, alucontrol};
         check("cycle", {12'd0, act_v}, {12'd0, exp_v});
      end
   end

   task automatic run(input logic [5:0] o, input logic [5:0] f, input logic [5:0] o_late,
                      output logic [31:0] trace, output int cyc,
                      output logic [7:0] rw_m, output logic [7:0] mw_m,
                      output logic [7:0] pc_m, output logic [2:0] alu_x);
      op = o;
      funct = f;
      #1;
      trace = {28'd0, state};
      rw_m = {7'd0, regwrite};
      mw_m = {7'd0, memwrite};
      pc_m = {7'd0, pcen};
      alu_x = 3'b000;
      cyc = 0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk);
         #1;
         cyc = i;
         trace = {trace[27:0], state};
         if (state == 4'd0) break;
         rw_m[i] = regwrite;
         mw_m[i] = memwrite;
         pc_m[i] = pcen;
         if (state == 4'd6 || state == 4'd8) alu_x = alucontrol;
         if (state == 4'd3 || state == 4'd6 || state == 4'd9) op = o_late;
      end
      check("return_fetch", {28'd0, state}, 32'd0);
   endtask

   logic [31:0] tr;
   int          cy;
   logic [7:0]  rw, mw, pc;
   logic [2:0]  ax;
   logic [5:0]  fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
   logic [2:0]  alus[6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      chk_en = 1'b1;
      check("rst_state", {28'd0, state}, 32'd0);
      check("rst_pcen", {31'd0, pcen}, 32'd1);
      check("rst_irwrite", {31'd0, irwrite}, 32'd1);
      check("rst_alusrcb", {30'd0, alusrcb}, 32'd1);
      check("rst_alucontrol", {29'd0, alucontrol}, 32'd2);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      run(6'b100011, 6'd0, 6'b000000, tr, cy, rw, mw, pc, ax);
      check("lw_trace", tr, 32'h0001_2340);
      check("lw_cycles", cy, 32'd5);
      check("lw_regwrite", {24'd0, rw}, 32'h10);
      check("lw_pcen", {24'd0, pc}, 32'h01);

      run(6'b101011, 6'd0, 6'b101011, tr, cy, rw, mw, pc, ax);
      check("sw_trace", tr, 32'h0000_1250);
      check("sw_cycles", cy, 32'd4);
      check("sw_memwrite", {24'd0, mw}, 32'h08);
      check("sw_regwrite", {24'd0, rw}, 32'h00);

      for (int k = 0; k < 6; k++) begin
         run(6'b000000, fns[k], 6'b100011, tr, cy, rw, mw, pc, ax);
         check("r_trace", tr, 32'h0000_1670);
         check("r_alucontrol", {29'd0, ax}, {29'd0, alus[k]});
         check("r_regwrite", {24'd0, rw}, 32'h08);
      end

      zero = 1'b1;
      run(6'b000100, 6'd0, 6'b000100, tr, cy, rw, mw, pc, ax);
      check("beq_trace", tr, 32'h0000_0180);
      check("beq_taken_pcen", {24'd0, pc}, 32'h05);
      check("beq_alucontrol", {29'd0, ax}, 32'd6);
      zero = 1'b0;
      run(6'b000100, 6'd0, 6'b000100, tr, cy, rw, mw, pc, ax);
      check("beq_not_taken_pcen", {24'd0, pc}, 32'h01);
      zero = 1'b1;
      #1 check("fetch_zero1_pcen", {31'd0, pcen}, 32'd1);
      zero = 1'b0;
      #1 check("fetch_zero0_pcen", {31'd0, pcen}, 32'd1);

      run(6'b000010, 6'd0, 6'b000010, tr, cy, rw, mw, pc, ax);
      check("j_trace", tr, 32'h0000_01B0);
      check("j_pcen", {24'd0, pc}, 32'h05);

      run(6'b111111, 6'd0, 6'b111111, tr, cy, rw, mw, pc, ax);
      check("ill_trace", tr, 32'h0000_0010);
      check("ill_cycles", cy, 32'd2);
      check("ill_flag", {31'd0, illegal}, 32'd1);

      run(6'b001000, 6'd0, 6'b111111, tr, cy, rw, mw, pc, ax);
      check("addi_trace", tr, 32'h0001_9A0);
      check("addi_regwrite", {24'd0, rw}, 32'h08);
      check("ill_sticky", {31'd0, illegal}, 32'd1);

      op = 6'b100011;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("mid_lw_memrd", {28'd0, state}, 32'd3);
      #1 reset = 1'b0;
      #1;
      check("async_state", {28'd0, state}, 32'd0);
      check("async_illegal", {31'd0, illegal}, 32'd0);
      check("async_regwrite", {31'd0, regwrite}, 32'd0);
      repeat (2) @(posedge clk);
      #1 check("held_regwrite", {31'd0, regwrite}, 32'd0);
      reset = 1'b1;

      run(6'b001000, 6'd0, 6'b001000, tr, cy, rw, mw, pc, ax);
      check("post_rst_addi_trace", tr, 32'h0001_9A0);
      check("post_rst_illegal", {31'd0, illegal}, 32'd0);

      @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
